// File: rtl/fft_frame_sequencer.sv
// Frame controller between a free-running sample source and an FFT core: gates N samples in,
// watches the core with a watchdog, re-emits the N output bins with index/last tags, counts frames and drops.
module fft_frame_sequencer #(
    parameter int N       = 1024,   // power of two, >= 2
    parameter int DW      = 16,
    parameter int TIMEOUT = 65535,  // >= 1
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    input  logic                 fft_ready,
    input  logic [DW-1:0]        fft_real,
    input  logic [DW-1:0]        fft_imag,
    input  logic                 fft_out_valid,
    output logic                 fft_start,
    output logic [DW-1:0]        fft_data_in,
    output logic                 fft_data_valid,
    output logic [DW-1:0]        m_real,
    output logic [DW-1:0]        m_imag,
    output logic                 m_valid,
    output logic [$clog2(N)-1:0] m_bin,
    output logic                 m_last,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int LW   = $clog2(N);
    localparam int CW   = LW + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_LOAD,
        S_PROCESS,
        S_UNLOAD
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             fft_start_q, fft_start_d;
    logic [DW-1:0]    fft_data_in_q, fft_data_in_d;
    logic             fft_data_valid_q, fft_data_valid_d;
    logic [DW-1:0]    m_real_q, m_real_d;
    logic [DW-1:0]    m_imag_q, m_imag_d;
    logic             m_valid_q, m_valid_d;
    logic [LW-1:0]    m_bin_q, m_bin_d;
    logic             m_last_q, m_last_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop;
    logic [CW-1:0]    word_idx;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d          = state_q;
        in_cnt_d         = in_cnt_q;
        out_cnt_d        = out_cnt_q;
        wd_d             = wd_q;
        fft_start_d      = 1'b0;
        fft_data_in_d    = fft_data_in_q;
        fft_data_valid_d = 1'b0;
        m_real_d         = m_real_q;
        m_imag_d         = m_imag_q;
        m_valid_d        = 1'b0;
        m_bin_d          = m_bin_q;
        m_last_d         = 1'b0;
        timeout_err_d    = timeout_err_q;
        frame_cnt_d      = frame_cnt_q;
        drop_cnt_d       = drop_cnt_q;
        drop             = 1'b0;
        word_idx         = (state_q == S_PROCESS) ? '0 : out_cnt_q;

        case (state_q)
            S_IDLE: begin
                drop = enable & s_valid;
                if (enable) state_d = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (fft_ready && s_valid) begin
                    fft_start_d      = 1'b1;
                    fft_data_in_d    = s_data;
                    fft_data_valid_d = 1'b1;
                    in_cnt_d         = CW'(1);
                    timeout_err_d    = 1'b0;
                    state_d          = S_LOAD;
                end else begin
                    drop = s_valid;
                end
            end
            S_LOAD: begin
                // start stays high through the cycle that shows the N-th sample to the core
                fft_start_d = 1'b1;
                if (s_valid) begin
                    fft_data_in_d    = s_data;
                    fft_data_valid_d = 1'b1;
                    in_cnt_d         = in_cnt_q + CW'(1);
                    if (in_cnt_q == CW'(N - 1)) begin
                        wd_d    = '0;
                        state_d = S_PROCESS;
                    end
                end
            end
            S_PROCESS: begin
                drop = enable & s_valid;
                if (!fft_out_valid) begin
                    if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end
            S_UNLOAD: begin
                drop = enable & s_valid;
            end
            default: state_d = S_IDLE;
        endcase

        // The first core word seen in PROCESS is bin 0; UNLOAD continues from out_cnt.
        if ((state_q == S_PROCESS || state_q == S_UNLOAD) && fft_out_valid) begin
            m_real_d  = fft_real;
            m_imag_d  = fft_imag;
            m_valid_d = 1'b1;
            m_bin_d   = word_idx[LW-1:0];
            out_cnt_d = word_idx + CW'(1);
            state_d   = S_UNLOAD;
            if (word_idx == CW'(N - 1)) begin
                m_last_d    = 1'b1;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                state_d     = enable ? S_WAIT_READY : S_IDLE;
            end
        end

        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            in_cnt_q         <= '0;
            out_cnt_q        <= '0;
            wd_q             <= '0;
            fft_start_q      <= 1'b0;
            fft_data_in_q    <= '0;
            fft_data_valid_q <= 1'b0;
            m_real_q         <= '0;
            m_imag_q         <= '0;
            m_valid_q        <= 1'b0;
            m_bin_q          <= '0;
            m_last_q         <= 1'b0;
            timeout_err_q    <= 1'b0;
            frame_cnt_q      <= '0;
            drop_cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q          <= state_d;
            in_cnt_q         <= in_cnt_d;
            out_cnt_q        <= out_cnt_d;
            wd_q             <= wd_d;
            fft_start_q      <= fft_start_d;
            fft_data_in_q    <= fft_data_in_d;
            fft_data_valid_q <= fft_data_valid_d;
            m_real_q         <= m_real_d;
            m_imag_q         <= m_imag_d;
            m_valid_q        <= m_valid_d;
            m_bin_q          <= m_bin_d;
            m_last_q         <= m_last_d;
            timeout_err_q    <= timeout_err_d;
            frame_cnt_q      <= frame_cnt_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    assign fft_start      = fft_start_q;
    assign fft_data_in    = fft_data_in_q;
    assign fft_data_valid = fft_data_valid_q;
    assign m_real         = m_real_q;
    assign m_imag         = m_imag_q;
    assign m_valid        = m_valid_q;
    assign m_bin          = m_bin_q;
    assign m_last         = m_last_q;
    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = timeout_err_q;
    assign frame_cnt      = frame_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
